// File: rtl/sentinel_pkg.sv
// Shared types for the Sentinel key presenter: FSM state enum and 7-seg glyphs.
// The 7-seg glyphs are used by sentinel_key_presenter when SENTINEL_PRESENTER_SEG_EN is defined.
package sentinel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESENT = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAIL    = 3'd4
    } sentinel_presenter_state_e;

    // Active-low {dp,g..a} glyphs.
    localparam logic [7:0] SegLocked   = 8'hC7;
    localparam logic [7:0] SegVerified = 8'hC1;
    localparam logic [7:0] SegOff      = 8'hFF;
    localparam logic [7:0] SegBusy     = 8'hBF;

    function automatic logic [7:0] seg_for_state(input sentinel_presenter_state_e s);
        logic [7:0] seg;
        seg = SegOff;
        case (s)
            ST_PRESENT, ST_BACKOFF: seg = SegBusy;
            ST_DONE:                seg = SegVerified;
            ST_FAIL:                seg = SegLocked;
            default:                seg = SegOff;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sentinel_cycle_timer.sv
// Down-counting cycle timer: load a value, count down while enabled, flag at zero.
// A single instance serves both the per-byte timeout and the retry backoff.
module sentinel_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sentinel_key_presenter.sv
// Sentinel initiator: presents KEY byte by byte over valid/ack/nak with timeout,
// bounded retries and backoff. Optional 7-seg status under SENTINEL_PRESENTER_SEG_EN.
module sentinel_key_presenter
    import sentinel_pkg::*;
#(
    parameter int                  KEY_LEN        = 4,
    parameter logic [8*KEY_LEN-1:0] KEY           = 32'h0FC35AB6,
    parameter int                  TIMEOUT_CYCLES = 255,
    parameter int                  MAX_RETRIES    = 3,
    parameter int                  BACKOFF_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] key_out,
    output logic       key_valid,
    input  logic       lock_ack,
    input  logic       lock_nak,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] attempt_cnt,
    output logic [7:0] seg_out,
    output logic [2:0] fsm_state
);

    localparam int TW_TO = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW_BO = $clog2(BACKOFF_CYCLES + 1);
    localparam int TW    = (TW_TO > TW_BO) ? TW_TO : TW_BO;
    localparam int IW    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

    // Loaded with N-1 so that expiry lands on the N-th counted cycle.
    localparam logic [TW-1:0] TimeoutLoad = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] BackoffLoad = TW'(BACKOFF_CYCLES - 1);
    localparam logic [IW-1:0] LastIdx     = IW'(KEY_LEN - 1);
    localparam logic [3:0]    MaxRetries  = 4'(MAX_RETRIES);

    sentinel_presenter_state_e state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [3:0]                att_q, att_d;
    logic                      tmr_load, tmr_clear, tmr_en, tmr_expired;
    logic [TW-1:0]             tmr_value;

    sentinel_cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .clear      (tmr_clear),
        .load_value (tmr_value),
        .enable     (tmr_en),
        .expired    (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        att_d     = att_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        tmr_value = TimeoutLoad;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d  = ST_PRESENT;
                    idx_d    = '0;
                    att_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_PRESENT: begin
                tmr_en = 1'b1;
                // nak beats ack; ack beats a simultaneous timeout.
                if (lock_nak || (!lock_ack && tmr_expired)) begin
                    if (att_q == MaxRetries) begin
                        state_d   = ST_FAIL;
                        tmr_clear = 1'b1;
                    end else begin
                        state_d   = ST_BACKOFF;
                        att_d     = att_q + 4'd1;
                        tmr_load  = 1'b1;
                        tmr_value = BackoffLoad;
                    end
                end else if (lock_ack) begin
                    if (idx_q == LastIdx) begin
                        state_d   = ST_DONE;
                        tmr_clear = 1'b1;
                    end else begin
                        idx_d    = idx_q + IW'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_BACKOFF: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d  = ST_PRESENT;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    assign key_valid   = (state_q == ST_PRESENT);
    assign key_out     = key_valid ? KEY[{idx_q, 3'b000} +: 8] : 8'h00;
    assign busy        = (state_q == ST_PRESENT) || (state_q == ST_BACKOFF);
    assign done        = (state_q == ST_DONE);
    assign fail        = (state_q == ST_FAIL);
    assign attempt_cnt = att_q;
    assign fsm_state   = state_q;

`ifdef SENTINEL_PRESENTER_SEG_EN
    // Decoded from next state so the digit changes on the same edge as the state.
    logic [7:0] seg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SegOff;
        end else begin
            seg_q <= seg_for_state(state_d);
        end
    end

    assign seg_out = seg_q;
`else
    assign seg_out = SegOff;
`endif

endmodule
